clk_gate_ctrl: RTL
==================

Name: clk_gate_ctrl

Overview:
- Automatic clock-gating controller; drives the enable input of a downstream integrated clock-gating cell (ICG).
- Runs on the free-running, ungated clock.
- Monitors an activity indicator from the gated domain and removes the clock enable after a programmable run of idle cycles.
- Restores the enable on a wake event, then holds off a ready indication for a fixed settle time. Also counts gating events.

Parameters:
- IdleCycles, 16, consecutive qualified-idle cycles before gating; legal range 1..65535; elaboration error if 0.
- WakeCycles, 2, cycles between enable re-assertion and ready_o; 0 allowed.
- CntWidth, 16, width of gating-event counter gate_cnt_o.

Ports:
- clk_i  input  1  free-running clock (ungated).
- rst_ni  input  1  reset; asynchronous assert, active-low.
- auto_en_i  input  1  permits automatic gating; 0 forces the clock on.
- busy_i  input  1  activity from the gated domain or its requesters.
- wake_i  input  1  external wake request (e.g. interrupt).
- force_on_i  input  1  debug/test override; clock always enabled.
- clk_en_o  output  1  registered enable to the ICG en_i.
- ready_o  output  1  gated domain clocked and settled; requesters may issue.
- gated_o  output  1  1 while the clock is gated.
- gate_cnt_o  output  CntWidth  number of RUN->GATED transitions; wraps.

Behaviour:
- Reset (rst_ni=0, async): state=RUN, clk_en_o=1, ready_o=1, gated_o=0, idle counter=0, wake counter=0, gate_cnt_o=0. Deassertion is synchronous to clk_i (synchronised externally).
- All outputs are registered; no combinational input-to-output path.
- idle_q = auto_en_i & ~busy_i & ~wake_i & ~force_on_i (combinational qualifier).
- Idle counter width is clog2(IdleCycles+1); it saturates and never wraps.
- States: RUN, GATED, WAKE.
- RUN: clk_en_o=1, ready_o=1, gated_o=0.
  - If idle_q and idle counter==IdleCycles-1: next state GATED, idle counter cleared, gate_cnt_o incremented.
  - Else if idle_q: idle counter +1.
  - Else: idle counter cleared.
  - Net effect: idle_q high on cycles t..t+IdleCycles-1 gives clk_en_o=0 from cycle t+IdleCycles. Any non-idle cycle restarts the count.
- GATED: clk_en_o=0, ready_o=0, gated_o=1.
  - If ~idle_q (busy, wake, force_on, or auto_en dropped): next state WAKE if WakeCycles>0, else RUN.
  - clk_en_o=1 on the next cycle; gated_o=0 on the next cycle.
- WAKE: clk_en_o=1, ready_o=0, gated_o=0.
  - Wake counter increments each cycle; when it reaches WakeCycles-1, next state RUN, idle counter and wake counter cleared.
  - Wake event at edge t gives clk_en_o=1 at t+1 and ready_o=1 at t+1+WakeCycles.
  - Inputs are ignored in WAKE; wake cannot be aborted.
- Priority: force_on_i and ~auto_en_i dominate. A gating transition never occurs in a cycle where either is active, even at counter terminal value.
- Simultaneous idle terminal count and busy_i rising: busy wins, stay RUN, counter cleared.
- Requesters seeing ready_o=0 must hold busy_i/request until ready_o=1. Such a busy_i is itself the wake source.
- gate_cnt_o wraps from 2^CntWidth-1 to 0 without flag.
- Reset mid-WAKE or mid-GATED: immediately clk_en_o=1, ready_o=1, state RUN. No glitch concern on the ICG, since the ICG latches en during clock low.
- IdleCycles=1: a single idle_q cycle in RUN gates on the next cycle.

Test Plan:
- Reset, IdleCycles=16, auto_en_i=1, busy_i=0 continuously -> clk_en_o=1 for 16 cycles after reset release, 0 from cycle 16; gated_o=1; gate_cnt_o=1.
- Idle 15 cycles, busy_i pulse 1 cycle, idle again -> no gating until 16 further idle cycles; gate_cnt_o stays 0 until then.
- In GATED, wake_i pulse at edge t (WakeCycles=2) -> clk_en_o=1 at t+1, ready_o=0 at t+1..t+2, ready_o=1 at t+3, gated_o=0 at t+1.
- force_on_i=1 with busy_i=0 for 100 cycles -> clk_en_o stays 1, gate_cnt_o=0. Release force_on_i -> gating after 16 idle cycles.
- WakeCycles=0, IdleCycles=1: alternate idle/wake every 2 cycles -> clk_en_o and ready_o rise together one cycle after wake; gate_cnt_o increments per gating. Preload near 0xFFFF via repetition -> wraps to 0.
- Assert rst_ni=0 asynchronously mid-WAKE (between edges) -> clk_en_o=1, ready_o=1, gated_o=0, gate_cnt_o=0 immediately, before the next clk_i edge.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
//
// Automatic clock-gating controller. It runs on the free-running clock and
// drives the enable of a downstream integrated clock-gating cell. After
// IdleCycles consecutive qualified-idle cycles it drops the enable. Any
// activity, wake request, force-on or auto-enable drop brings the enable back.
// After the enable returns, ready_o stays low for WakeCycles cycles so the
// gated domain can settle. The number of gating events is counted and the
// count wraps.
//
// Ports:
//   clk_i       free-running (ungated) clock
//   rst_ni      asynchronous active-low reset
//   auto_en_i   1 permits automatic gating, 0 forces the clock on
//   busy_i      activity from the gated domain or its requesters
//   wake_i      external wake request
//   force_on_i  debug/test override, keeps the clock enabled
//   clk_en_o    registered enable to the ICG
//   ready_o     gated domain clocked and settled
//   gated_o     1 while the clock is gated
//   gate_cnt_o  number of RUN->GATED transitions (wraps)
// ---------------------------------------------------------------------------
module clk_gate_ctrl #(
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                auto_en_i,
    input  logic                busy_i,
    input  logic                wake_i,
    input  logic                force_on_i,
    output logic                clk_en_o,
    output logic                ready_o,
    output logic                gated_o,
    output logic [CntWidth-1:0] gate_cnt_o
);

    localparam int unsigned IdleW = $clog2(IdleCycles + 1);
    localparam int unsigned WakeW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;

    localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleCycles - 1);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleCycles);
    localparam logic [WakeW-1:0] WakeLast = WakeW'((WakeCycles == 0) ? 0 : WakeCycles - 1);

    // A zero idle threshold would gate with no idle cycles at all.
    if (IdleCycles == 0 || IdleCycles > 65535) begin : g_idle_range_check
        $error("clk_gate_ctrl: IdleCycles must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_e;

    state_e              state_q,    state_d;
    logic [IdleW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [WakeW-1:0]    wake_cnt_q, wake_cnt_d;
    logic [CntWidth-1:0] gate_cnt_q, gate_cnt_d;
    logic                clk_en_q,   clk_en_d;
    logic                ready_q,    ready_d;
    logic                gated_q,    gated_d;
    logic                idle_qual;

    // Force-on and a dropped auto-enable disqualify idleness. This keeps a
    // gating transition from ever happening while either one is active.
    assign idle_qual = auto_en_i & ~busy_i & ~wake_i & ~force_on_i;

    // Next-state logic. The outputs are decoded from the next state and
    // registered, so each output flop matches the state it belongs to and
    // no input reaches an output combinationally.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        gate_cnt_d = gate_cnt_q;

        unique case (state_q)
            ST_RUN: begin
                if (idle_qual && idle_cnt_q == IdleLast) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                    gate_cnt_d = gate_cnt_q + CntWidth'(1);
                end else if (idle_qual) begin
                    if (idle_cnt_q != IdleMax) begin
                        idle_cnt_d = idle_cnt_q + IdleW'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_GATED: begin
                idle_cnt_d = '0;
                if (!idle_qual) begin
                    wake_cnt_d = '0;
                    state_d    = (WakeCycles > 0) ? ST_WAKE : ST_RUN;
                end
            end
            ST_WAKE: begin
                // The settle period cannot be aborted, so inputs are ignored here.
                if (wake_cnt_q == WakeLast) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WakeW'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase

        clk_en_d = (state_d != ST_GATED);
        ready_d  = (state_d == ST_RUN);
        gated_d  = (state_d == ST_GATED);
    end

    // State and output registers. Reset puts the clock on and the domain
    // ready at once. The ICG latches its enable while the clock is low, so
    // an asynchronous change here does not glitch the gated clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_cnt_q <= '0;
            clk_en_q   <= 1'b1;
            ready_q    <= 1'b1;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            clk_en_q   <= clk_en_d;
            ready_q    <= ready_d;
            gated_q    <= gated_d;
        end
    end

    assign clk_en_o   = clk_en_q;
    assign ready_o    = ready_q;
    assign gated_o    = gated_q;
    assign gate_cnt_o = gate_cnt_q;

endmodule
